fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_reader.sv | 91 +++++++++
 tb/tb_fifo_stream_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: pops words and presents them on a valid/ready
// stream through a 2-entry skid buffer. Define FIFO_STREAM_READER_LAST_EN to enable m_last.
module fifo_stream_reader #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              idle
);

    logic [1:0]        r_occ;
    logic              r_pend;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;

    logic              w_pop;
    logic [1:0]        w_held;
    logic [1:0]        w_occ_next;
    logic [DATA_W-1:0] w_buf0_next;
    logic [DATA_W-1:0] w_buf1_next;

    // Handshake: a word transfers on any cycle where m_valid and m_ready are both high;
    // m_valid/m_data never change while m_valid is high and m_ready is low.
    assign w_pop      = r_m_valid & m_ready;
    assign w_held     = r_occ - {1'b0, w_pop};
    assign w_occ_next = w_held + {1'b0, r_pend};
    // Counting the in-flight word guarantees it always has a free slot when it lands.
    assign fifo_rd_en = reset_n & en & ~fifo_empty & (w_occ_next < 2'd2);

    always_comb begin
        w_buf0_next = r_buf0;
        w_buf1_next = r_buf1;
        if (w_pop)
            w_buf0_next = r_buf1;
        if (r_pend) begin
            if (w_held == 2'd0)
                w_buf0_next = fifo_data;
            else
                w_buf1_next = fifo_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ     <= 2'd0;
            r_pend    <= 1'b0;
            r_m_valid <= 1'b0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else begin
            r_occ     <= w_occ_next;
            r_pend    <= fifo_rd_en;
            r_m_valid <= (w_occ_next != 2'd0);
            r_buf0    <= w_buf0_next;
            r_buf1    <= w_buf1_next;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_buf0;
    assign idle    = (r_occ == 2'd0) & ~r_pend;

`ifdef FIFO_STREAM_READER_LAST_EN
    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0] r_beat_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_beat_cnt <= '0;
        else if (w_pop)
            r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
    end

    assign m_last = r_m_valid & (r_beat_cnt == LAST_BEAT);
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, random back-pressure, scoreboard on the stream.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          idle;

    fifo_stream_reader #(.DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .idle(idle)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] load_q[$];
    logic [DW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int exp_beat = 0;
    int last_hits = 0;
    bit rdy_rand = 0;
    bit en_rand = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural FIFO: registered read data one cycle after an accepted pop.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0)
                fifo_data <= fifo_q.pop_front();
        end
        while (load_q.size() > 0)
            fifo_q.push_back(load_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Stream monitor: words must leave in load order; m_last marks every BL-th beat.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_beat   = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid) begin
`ifdef FIFO_STREAM_READER_LAST_EN
                check("m_last", 32'(m_last), 32'((exp_beat % BL) == BL - 1));
`else
                check("m_last", 32'(m_last), 32'd0);
`endif
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                    end else begin
                        check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
                    end
                    if (m_last) last_hits++;
                    exp_beat++;
                end
            end else begin
                check("m_last_idle", 32'(m_last), 32'd0);
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
        if (en_rand)  en = ($urandom_range(0, 3) != 0);
    endtask

    task automatic load_word(input logic [DW-1:0] w);
        load_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (i < budget && !(exp_q.size() == 0 && idle && fifo_q.size() == 0 && load_q.size() == 0)) begin
            tick();
            i++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(idle), 32'd1);
    endtask

    task automatic wait_rd_en(input int budget);
        int i;
        i = 0;
        while (i < budget && !fifo_rd_en) begin
            tick();
            i++;
        end
        check("rd_en_wait", 32'(fifo_rd_en), 32'd1);
    endtask

    initial begin
        int n;
        // Reset with a non-empty FIFO.
        for (int i = 1; i <= 16; i++) load_word(DW'(i));
        repeat (3) tick();
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_last", 32'(m_last), 32'd0);
        reset_n = 1'b1;
        #1;
        check("first_rd_en", 32'(fifo_rd_en), 32'd1);

        // Streaming latency and no-bubble throughput.
        tick();
        check("lat_n1_valid", 32'(m_valid), 32'd0);
        tick();
        check("lat_n2_valid", 32'(m_valid), 32'd1);
        check("lat_n2_data", 32'(m_data), 32'h01);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("no_bubble", 32'(m_valid), 32'd1);
            check("rd_en_fall", 32'(fifo_rd_en), 32'(i < 13));
        end
        tick();
        check("stream_end_valid", 32'(m_valid), 32'd0);
        check("stream_end_idle", 32'(idle), 32'd1);

        // Back-pressure: only two pops with m_ready low.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) load_word(DW'(8'h20 + i));
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n += int'(fifo_rd_en);
        end
        check("bp_pops", 32'(n), 32'd2);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_data", 32'(m_data), 32'h20);
        m_ready = 1'b1;
        wait_drain(100);

        // Enable gating with a pop in flight.
        for (int i = 0; i < 6; i++) load_word(DW'(8'h30 + i));
        wait_rd_en(10);
        tick();
        en = 1'b0;
        #1;
        check("en_drop_rd_en", 32'(fifo_rd_en), 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n += int'(fifo_rd_en);
        end
        check("en_low_pops", 32'(n), 32'd0);
        check("en_low_left", 32'(exp_q.size()), 32'd5);
        check("en_low_idle", 32'(idle), 32'd1);
        en = 1'b1;
        wait_drain(100);

        // Random load, back-pressure and enable.
        rdy_rand = 1;
        en_rand  = 1;
        for (int i = 0; i < 40; i++) begin
            load_word(DW'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_drain(2000);
        rdy_rand = 0;
        en_rand  = 0;
        en       = 1'b1;
        m_ready  = 1'b1;

        // Asynchronous reset with buffered and in-flight words.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load_word(DW'(8'h50 + i));
        wait_rd_en(10);
        tick();
        tick();
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        check("pre_rst_idle", 32'(idle), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", 32'(m_valid), 32'd0);
        check("async_data", 32'(m_data), 32'd0);
        check("async_idle", 32'(idle), 32'd1);
        check("async_rd_en", 32'(fifo_rd_en), 32'd0);
        exp_q = {fifo_q, load_q};
        check("rst_fifo_left", 32'(exp_q.size()), 32'd3);
        tick();
        tick();
        reset_n = 1'b1;
        m_ready = 1'b1;
        wait_drain(100);

        // Burst marking from a clean reset, under random stalls.
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        last_hits = 0;
        rdy_rand = 1;
        for (int i = 0; i < 8; i++) load_word(DW'(8'hA0 + i));
        wait_drain(500);
        rdy_rand = 0;
`ifdef FIFO_STREAM_READER_LAST_EN
        check("last_hits", 32'(last_hits), 32'd2);
`else
        check("last_hits", 32'(last_hits), 32'd0);
`endif

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end
endmodule
